// File: rtl/speed_display_mux.sv
// Seven-segment speed display: handshake-fed binary sample, sequential double-dabble
// BCD conversion, multiplexed digit scan with leading-zero blanking and a blinking no-fix dash.
module speed_display_mux #(
    parameter int unsigned width_p       = 8,
    parameter int unsigned digits_p      = 2,
    parameter int unsigned refresh_div_p = 6000,
    parameter int unsigned blink_div_p   = 6000000,
    parameter int unsigned lzb_p         = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic [width_p-1:0]  value_i,
    output logic                ready_o,
    input  logic                fix_i,
    output logic [6:0]          ssd_o,
    output logic [digits_p-1:0] dig_en_o,
    output logic                overflow_o
);

    localparam int unsigned bcd_digits_lp = (width_p + 2) / 3;
    localparam int unsigned bcd_w_lp      = 4 * bcd_digits_lp;
    localparam int unsigned ext_w_lp      = 4 * (bcd_digits_lp + digits_p);
    localparam int unsigned step_w_lp     = (width_p > 1) ? $clog2(width_p) : 1;
    localparam int unsigned ref_w_lp      = (refresh_div_p > 1) ? $clog2(refresh_div_p) : 1;
    localparam int unsigned blk_w_lp      = (blink_div_p > 1) ? $clog2(blink_div_p) : 1;
    localparam int unsigned idx_w_lp      = (digits_p > 1) ? $clog2(digits_p) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_r;
    logic [width_p-1:0]    shift_r;
    logic [bcd_w_lp-1:0]   bcd_r;
    logic [bcd_w_lp-1:0]   bcd_adj;
    logic [step_w_lp-1:0]  step_r;
    logic [4*digits_p-1:0] disp_r;
    logic                  ovf_r;

    logic [ext_w_lp-1:0]   bcd_ext;
    logic                  commit_ovf;
    logic [4*digits_p-1:0] commit_digits;

    logic [ref_w_lp-1:0]   refresh_r;
    logic [idx_w_lp-1:0]   idx_r;
    logic [blk_w_lp-1:0]   blink_cnt_r;
    logic                  blink_on_r;

    logic [3:0]            sel_digit;
    logic                  sel_keep;
    logic                  keep;
    logic [digits_p-1:0]   en_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    assign ready_o    = !rst_i && (state_r == IDLE);
    assign overflow_o = ovf_r;

    // Add-3 correction on every BCD digit that would reach 10 or more after the shift.
    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < bcd_digits_lp; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_r[4*i +: 4];
        end
    end

    // Zero-extend so the overflow slice exists even when digits_p covers every BCD digit.
    always_comb begin
        bcd_ext       = {{(4*digits_p){1'b0}}, bcd_r};
        commit_ovf    = |bcd_ext[ext_w_lp-1:4*digits_p];
        commit_digits = bcd_ext[4*digits_p-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            shift_r <= '0;
            bcd_r   <= '0;
            step_r  <= '0;
            disp_r  <= '0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        shift_r <= value_i;
                        bcd_r   <= '0;
                        step_r  <= '0;
                        state_r <= CONV;
                    end
                end
                CONV: begin
                    {bcd_r, shift_r} <= {bcd_adj, shift_r} << 1;
                    step_r <= step_r + step_w_lp'(1);
                    if (step_r == step_w_lp'(width_p - 1))
                        state_r <= DONE;
                end
                DONE: begin
                    if (commit_ovf) begin
                        disp_r <= {digits_p{4'h9}};
                        ovf_r  <= 1'b1;
                    end else begin
                        disp_r <= commit_digits;
                        ovf_r  <= 1'b0;
                    end
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            refresh_r <= '0;
            idx_r     <= '0;
        end else if (refresh_r == ref_w_lp'(refresh_div_p - 1)) begin
            refresh_r <= '0;
            if (idx_r == idx_w_lp'(digits_p - 1))
                idx_r <= '0;
            else
                idx_r <= idx_r + idx_w_lp'(1);
        end else begin
            refresh_r <= refresh_r + ref_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || fix_i) begin
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
        end else if (blink_cnt_r == blk_w_lp'(blink_div_p - 1)) begin
            blink_cnt_r <= '0;
            blink_on_r  <= !blink_on_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + blk_w_lp'(1);
        end
    end

    // A digit stays lit only if it or some more significant digit is nonzero.
    always_comb begin
        sel_digit = '0;
        sel_keep  = 1'b0;
        keep      = 1'b0;
        en_next   = '0;
        for (int unsigned i = 0; i < digits_p; i++) begin
            keep = 1'b0;
            for (int unsigned j = i; j < digits_p; j++)
                keep = keep | (disp_r[4*j +: 4] != 4'd0);
            if (idx_r == idx_w_lp'(i)) begin
                sel_digit  = disp_r[4*i +: 4];
                sel_keep   = keep || (i == 0) || (lzb_p == 0);
                en_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ssd_o    <= 7'h00;
            dig_en_o <= digits_p'(1);
        end else begin
            dig_en_o <= en_next;
            if (fix_i)
                ssd_o <= sel_keep ? decode(sel_digit) : 7'h00;
            else
                ssd_o <= blink_on_r ? 7'h40 : 7'h00;
        end
    end

endmodule
